// File: rtl/adder_seq_pkg.sv
// Shared types and defaults for the adder-chain sequencer.
package adder_seq_pkg;

  localparam int BW_DEF         = 8;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int AMOUNT_DEF     = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_DRAIN,
    S_HOLD
  } seq_state_t;

  // One cycle of ROM read latency plus one per adder stage.
  function automatic int drain_cyc(input int amount);
    return amount + 1;
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with a zero flag; holds at zero.
module seq_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/adder_chain_sequencer.sv
// Sequences one accumulation job on the ROM-fed cascaded adder chain.
// Optional job/cycle statistics outputs are built when SEQ_STATS_EN is defined.
//
//  state   | meaning
//  --------+-------------------------------------------------
//  S_IDLE  | ready for a job, chain held clear
//  S_CLEAR | one-cycle chain clear before issuing
//  S_ISSUE | one ROM read per cycle, len cycles
//  S_DRAIN | wait out ROM + adder pipeline, capture sum on last cycle
//  S_HOLD  | result presented until consumer takes it
module adder_chain_sequencer
  import adder_seq_pkg::*;
#(
  parameter int BW         = BW_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int AMOUNT     = AMOUNT_DEF,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  start_len,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  chain_clr,
  input  logic [BW-1:0]         chain_sum,
  output logic                  busy,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [BW-1:0]         res_data
`ifdef SEQ_STATS_EN
  ,
  output logic [15:0]           job_cnt,
  output logic [31:0]           cyc_cnt
`endif
);

  localparam int DRAIN_CYC = drain_cyc(AMOUNT);
  localparam int DRAIN_W   = $clog2(DRAIN_CYC) + 1;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(2 ** ADDR_WIDTH);

  seq_state_t state_q, state_d;

  logic [LEN_WIDTH-1:0]  len_clamped;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BW-1:0]         res_q;
  logic accept, empty_job;
  logic issue_load, issue_dec, issue_zero;
  logic drain_load, drain_dec, drain_zero;
  logic capture;

  always_comb begin
    len_clamped = (start_len > MAX_LEN) ? MAX_LEN : start_len;
  end

  assign accept    = (state_q == S_IDLE) && start_valid;
  assign empty_job = (len_clamped == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    issue_load  = 1'b0;
    issue_dec   = 1'b0;
    drain_load  = 1'b0;
    drain_dec   = 1'b0;
    capture     = 1'b0;
    start_ready = 1'b0;
    chain_clr   = 1'b0;
    rom_en      = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b1;
    case (state_q)
      S_IDLE: begin
        start_ready = 1'b1;
        chain_clr   = 1'b1;
        busy        = 1'b0;
        if (start_valid) begin
          issue_load = 1'b1;
          state_d    = empty_job ? S_HOLD : S_CLEAR;
        end
      end
      S_CLEAR: begin
        chain_clr = 1'b1;
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        rom_en = 1'b1;
        if (issue_zero) begin
          drain_load = 1'b1;
          state_d    = S_DRAIN;
        end else begin
          issue_dec = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_zero) begin
          capture = 1'b1;
          state_d = S_HOLD;
        end else begin
          drain_dec = 1'b1;
        end
      end
      S_HOLD: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Counters are loaded with (cycles - 1) so the zero flag marks the last cycle.
  seq_down_counter #(.W(LEN_WIDTH)) u_issue_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (issue_load),
    .load_val (len_clamped - LEN_WIDTH'(1)),
    .dec      (issue_dec),
    .zero     (issue_zero)
  );

  seq_down_counter #(.W(DRAIN_W)) u_drain_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (drain_load),
    .load_val (DRAIN_W'(DRAIN_CYC - 1)),
    .dec      (drain_dec),
    .zero     (drain_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      res_q  <= '0;
    end else begin
      if (accept) begin
        addr_q <= start_addr;
      end else if (state_q == S_ISSUE) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
      end
      if (accept && empty_job) begin
        res_q <= '0;
      end else if (capture) begin
        res_q <= chain_sum;
      end
    end
  end

  assign rom_addr = addr_q;
  assign res_data = res_q;

`ifdef SEQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_cnt <= '0;
      cyc_cnt <= '0;
    end else begin
      if ((state_q == S_HOLD) && res_ready && (job_cnt != '1)) begin
        job_cnt <= job_cnt + 16'd1;
      end
      if (busy && (cyc_cnt != '1)) begin
        cyc_cnt <= cyc_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adder_chain_sequencer.sv
// Directed bench for adder_chain_sequencer with a ROM[i]=i+1 and 5-cycle chain model.
module tb_adder_chain_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_valid, start_ready;
  logic [3:0] start_addr;
  logic [4:0] start_len;
  logic       rom_en;
  logic [3:0] rom_addr;
  logic       chain_clr;
  logic [7:0] chain_sum;
  logic       busy, res_valid, res_ready;
  logic [7:0] res_data;
`ifdef SEQ_STATS_EN
  logic [15:0] job_cnt;
  logic [31:0] cyc_cnt;
`endif

  adder_chain_sequencer #(
    .BW(8), .ADDR_WIDTH(4), .AMOUNT(4), .LEN_WIDTH(5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_addr  (start_addr),
    .start_len   (start_len),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .chain_clr   (chain_clr),
    .chain_sum   (chain_sum),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data)
`ifdef SEQ_STATS_EN
    ,
    .job_cnt     (job_cnt),
    .cyc_cnt     (cyc_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ROM (1 cycle) -> accumulator -> 3 pipeline regs: 5 cycles address-to-sum.
  logic [7:0] rom_q, acc, d0, d1, d2;
  always @(posedge clk) begin
    if (chain_clr) begin
      rom_q <= 8'd0; acc <= 8'd0; d0 <= 8'd0; d1 <= 8'd0; d2 <= 8'd0;
    end else begin
      rom_q <= rom_en ? (8'(rom_addr) + 8'd1) : 8'd0;
      acc   <= acc + rom_q;
      d0    <= acc;
      d1    <= d0;
      d2    <= d1;
    end
  end
  assign chain_sum = d2;

  typedef struct {
    logic [3:0] addr;
    logic [4:0] len;
    logic [7:0] sum;
    int         n;
    int         lat;
  } vec_t;

  vec_t vecs[7];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic start_job(input logic [3:0] a, input logic [4:0] l);
    @(negedge clk);
    start_addr  = a;
    start_len   = l;
    start_valid = 1'b1;
    chk("start_ready_idle", start_ready, 1);
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  // Entered at the negedge of the first cycle after accept.
  task automatic wait_result(input string tag, input logic [3:0] a, input int exp_n,
                             input int exp_lat, input logic [7:0] exp_sum);
    int lat;
    int n;
    logic [3:0] ea;
    bit addr_ok;
    bit sr_ok;
    lat = 1; n = 0; ea = a; addr_ok = 1'b1; sr_ok = 1'b1;
    while (!res_valid && lat < 100) begin
      if (rom_en) begin
        if (rom_addr !== ea) addr_ok = 1'b0;
        ea = ea + 4'd1;
        n++;
      end
      if (start_ready) sr_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_rom_reads"}, n, exp_n);
    chk({tag, "_addr_seq"}, addr_ok, 1);
    chk({tag, "_start_ready_low"}, sr_ok, 1);
    chk({tag, "_res_data"}, res_data, exp_sum);
  endtask

  task automatic pop(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_res_valid"}, res_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit stable_ok;
    rst = 1'b1; start_valid = 1'b0; start_addr = '0; start_len = '0; res_ready = 1'b0;

    vecs[0] = '{addr: 4'd2,  len: 5'd3,  sum: 8'd12,  n: 3,  lat: 10};
    vecs[1] = '{addr: 4'd14, len: 5'd4,  sum: 8'd34,  n: 4,  lat: 11};
    vecs[2] = '{addr: 4'd5,  len: 5'd0,  sum: 8'd0,   n: 0,  lat: 1};
    vecs[3] = '{addr: 4'd0,  len: 5'd31, sum: 8'd136, n: 16, lat: 23};
    vecs[4] = '{addr: 4'd15, len: 5'd1,  sum: 8'd16,  n: 1,  lat: 8};
    vecs[5] = '{addr: 4'd9,  len: 5'd16, sum: 8'd136, n: 16, lat: 23};
    vecs[6] = '{addr: 4'd3,  len: 5'd17, sum: 8'd136, n: 16, lat: 23};

    repeat (2) @(negedge clk);
    chk("rst_start_ready", start_ready, 1);
    chk("rst_rom_en", rom_en, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_chain_clr", chain_clr, 1);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      start_job(vecs[i].addr, vecs[i].len);
      wait_result($sformatf("vec%0d", i), vecs[i].addr, vecs[i].n, vecs[i].lat, vecs[i].sum);
      pop($sformatf("vec%0d", i));
`ifdef SEQ_STATS_EN
      if (i == 1) begin
        chk("stats_job_cnt", job_cnt, 2);
        chk("stats_cyc_cnt", cyc_cnt, 21);
      end
`endif
    end

    // Result held under back-pressure, then a start in the pop cycle is deferred.
    start_job(4'd0, 5'd7);
    wait_result("hold", 4'd0, 7, 14, 8'd28);
    stable_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== 8'd28) stable_ok = 1'b0;
    end
    chk("hold_stable", stable_ok, 1);
    res_ready = 1'b1; start_valid = 1'b1; start_addr = 4'd2; start_len = 5'd3;
    @(negedge clk);
    res_ready = 1'b0;
    chk("pop_start_not_taken_busy", busy, 0);
    chk("pop_start_not_taken_ready", start_ready, 1);
    @(negedge clk);
    start_valid = 1'b0;
    chk("deferred_start_busy", busy, 1);
    chk("deferred_start_clr", chain_clr, 1);
    wait_result("deferred", 4'd2, 3, 10, 8'd12);
    pop("deferred");

    // Reset in the second ISSUE cycle abandons the job.
    start_job(4'd2, 5'd3);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_issuing", rom_en, 1);
    rst = 1'b1;
    #1;
    chk("midrst_rom_en", rom_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_chain_clr", chain_clr, 1);
    chk("midrst_rom_addr", rom_addr, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_res_data", res_data, 0);
    @(negedge clk);
    rst = 1'b0;
    start_job(4'd2, 5'd3);
    wait_result("after_rst", 4'd2, 3, 10, 8'd12);
    pop("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
